// File: rtl/imem_load_ctrl.sv
// Boot loader: receives a 4-byte little-endian word count followed by that many
// little-endian 32-bit words over a byte stream, and writes them to instruction memory.
// Latency: each memory write is issued one cycle after the last byte of its word is accepted.
//          In DONE, core stores pass to memory after one registered cycle.
// Backpressure: rx_ready is high for the whole load and low once it is DONE.
//               While a load runs, the core is stalled and its stores are dropped.
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   rx_valid/rx_data/rx_ready   - byte stream from the UART receiver
//   reload                      - starts a new load (honoured only in DONE)
//   core_we/addr/wdata          - core stores to instruction memory (honoured only in DONE)
//   mem_we/addr/wdata           - instruction-memory write port
//   core_stall, load_done       - core run control
//   len_err                     - header count was clipped to MAX_WORDS
module imem_load_ctrl #(
  parameter logic [11:0] BASE      = 12'h000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  input  logic        core_we,
  input  logic [11:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_stall,
  output logic        load_done,
  output logic        len_err
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [1:0] {HDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [11:0] word_idx;
  logic [31:0] count;
  logic [23:0] word_asm;
  logic [31:0] remaining;

  logic        rx_fire;
  logic        last_byte;
  logic [31:0] hdr_n;

  assign rx_fire   = rx_valid && rx_ready;
  assign last_byte = (byte_cnt == 2'd3);
  // Bytes shift in from the top, so the first byte ends up in bits 7:0.
  assign hdr_n     = {rx_data, count[31:8]};

  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rx_ready   = (state != DONE);
    core_stall = (state != DONE);
    load_done  = (state == DONE);
    case (state)
      HDR: begin
        if (rx_fire && last_byte)
          state_nxt = (hdr_n == 32'd0) ? DONE : DATA;
      end
      DATA: begin
        // Leave on the same edge that launches the final write.
        if (rx_fire && last_byte && remaining == 32'd1)
          state_nxt = DONE;
      end
      DONE: begin
        if (reload) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= 2'd0;
      word_idx  <= 12'd0;
      count     <= 32'd0;
      word_asm  <= 24'd0;
      remaining <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 12'd0;
      mem_wdata <= 32'd0;
      len_err   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR: begin
          if (rx_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            count    <= hdr_n;
            if (last_byte) begin
              remaining <= (hdr_n > MAX_W) ? MAX_W : hdr_n;
              word_idx  <= 12'd0;
              len_err   <= (hdr_n > MAX_W);
            end
          end
        end
        DATA: begin
          if (rx_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_asm <= {rx_data, word_asm[23:8]};
            if (last_byte) begin
              mem_we    <= 1'b1;
              mem_addr  <= BASE + word_idx;
              mem_wdata <= {rx_data, word_asm};
              word_idx  <= word_idx + 12'd1;
              remaining <= remaining - 32'd1;
            end
          end
        end
        DONE: begin
          // Core stores are still honoured in the cycle a reload is requested.
          mem_we <= core_we;
          if (core_we) begin
            mem_addr  <= core_addr;
            mem_wdata <= core_wdata;
          end
          if (reload) begin
            byte_cnt <= 2'd0;
            word_idx <= 12'd0;
            count    <= 32'd0;
            len_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        reload;
  logic        core_we;
  logic [11:0] core_addr;
  logic [31:0] core_wdata;

  logic        rx_ready, mem_we, core_stall, load_done, len_err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        rx_ready4, mem_we4, core_stall4, load_done4, len_err4;
  logic [11:0] mem_addr4;
  logic [31:0] mem_wdata4;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_stall(core_stall), .load_done(load_done), .len_err(len_err)
  );

  imem_load_ctrl #(.MAX_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready4),
    .reload(reload), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .core_stall(core_stall4), .load_done(load_done4), .len_err(len_err4)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitors: {load_done, addr, data} for every cycle mem_we is high.
  logic [44:0] wr_q[$];
  logic [44:0] wr4_q[$];
  logic [43:0] exp_q[$];

  always @(negedge clk) begin
    if (mem_we)  wr_q.push_back({load_done, mem_addr, mem_wdata});
    if (mem_we4) wr4_q.push_back({load_done4, mem_addr4, mem_wdata4});
  end

  task automatic cmp_writes(input string tag, input bit use4);
    int n;
    logic [44:0] e;
    n = use4 ? wr4_q.size() : wr_q.size();
    check({tag, ".count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      e = use4 ? wr4_q[i] : wr_q[i];
      check($sformatf("%s.wr%0d", tag, i), 64'(e[43:0]), 64'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_q.delete();
    wr4_q.delete();
    rst      = 1'b1;
    rx_valid = 1'b0;
    reload   = 1'b0;
    core_we  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Gap before byte j is (gap_base + j) % 6 when gapped, else zero.
  task automatic send_word(input logic [31:0] w, input bit gapped, input int gap_base);
    for (int j = 0; j < 4; j++)
      send_byte(w[8*j +: 8], gapped ? (gap_base + j) % 6 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    core_we = 1'b0; core_addr = 12'h000; core_wdata = 32'h0;

    // Reset state
    do_reset();
    check("rst.mem_we",     64'(mem_we),     64'd0);
    check("rst.mem_addr",   64'(mem_addr),   64'd0);
    check("rst.mem_wdata",  64'(mem_wdata),  64'd0);
    check("rst.core_stall", 64'(core_stall), 64'd1);
    check("rst.load_done",  64'(load_done),  64'd0);
    check("rst.rx_ready",   64'(rx_ready),   64'd1);
    check("rst.len_err",    64'(len_err),    64'd0);

    // Two-word load, back to back
    send_word(32'd2, 0, 0);
    send_word(32'h0000_0013, 0, 0);
    send_word(32'h0010_0093, 0, 0);
    idle(3);
    exp_q.delete();
    exp_q.push_back({12'h000, 32'h0000_0013});
    exp_q.push_back({12'h001, 32'h0010_0093});
    cmp_writes("two_word", 0);
    if (wr_q.size() == 2) begin
      check("two_word.done_w0", 64'(wr_q[0][44]), 64'd0);
      check("two_word.done_w1", 64'(wr_q[1][44]), 64'd1);
    end
    check("two_word.load_done",  64'(load_done),  64'd1);
    check("two_word.core_stall", 64'(core_stall), 64'd0);
    check("two_word.rx_ready",   64'(rx_ready),   64'd0);
    check("two_word.len_err",    64'(len_err),    64'd0);

    // Core store in DONE: one cycle latency, then address/data hold
    @(negedge clk);
    core_we = 1'b1; core_addr = 12'h0FF; core_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    core_we = 1'b0;
    check("done_st.mem_we",    64'(mem_we),    64'd1);
    check("done_st.mem_addr",  64'(mem_addr),  64'h0FF);
    check("done_st.mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    @(negedge clk);
    check("hold.mem_we",    64'(mem_we),    64'd0);
    check("hold.mem_addr",  64'(mem_addr),  64'h0FF);
    check("hold.mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);

    // Reload with a simultaneous core store
    reload = 1'b1; core_we = 1'b1; core_addr = 12'h123; core_wdata = 32'h5555_AAAA;
    @(negedge clk);
    reload = 1'b0; core_we = 1'b0;
    check("reload.core_stall", 64'(core_stall), 64'd1);
    check("reload.rx_ready",   64'(rx_ready),   64'd1);
    check("reload.load_done",  64'(load_done),  64'd0);
    check("reload.mem_we",     64'(mem_we),     64'd1);
    check("reload.mem_addr",   64'(mem_addr),   64'h123);
    check("reload.mem_wdata",  64'(mem_wdata),  64'h5555_AAAA);
    @(negedge clk);
    check("reload.mem_we_off", 64'(mem_we), 64'd0);

    // Core store during DATA is dropped
    do_reset();
    send_word(32'd1, 0, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    core_we = 1'b1; core_addr = 12'h0FF; core_wdata = 32'hDEAD_BEEF;
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    idle(1);
    core_we = 1'b0;
    idle(2);
    exp_q.delete();
    exp_q.push_back({12'h000, 32'h1234_5678});
    cmp_writes("data_st", 0);

    // Zero-length header
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("zero.done_before", 64'(load_done), 64'd0);
    idle(1);
    check("zero.done_after", 64'(load_done), 64'd1);
    idle(3);
    exp_q.delete();
    cmp_writes("zero", 0);
    check("zero.len_err", 64'(len_err), 64'd0);

    // Over-length header clipped to MAX_WORDS=4
    do_reset();
    send_word(32'd6, 0, 0);
    for (int i = 0; i < 24; i++) begin
      send_byte(8'(i), 0);
      if (i == 15) check("clip.rx_ready_b16", 64'(rx_ready4), 64'd1);
      if (i == 16) check("clip.rx_ready_b17", 64'(rx_ready4), 64'd0);
    end
    idle(3);
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      exp_q.push_back({12'(k), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    cmp_writes("clip", 1);
    check("clip.len_err4",    64'(len_err4),    64'd1);
    check("clip.load_done4",  64'(load_done4),  64'd1);
    check("clip.len_err_def", 64'(len_err),     64'd0);
    check("clip.count_def",   64'(wr_q.size()), 64'd6);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("clip.len_err_clr", 64'(len_err4), 64'd0);

    // Gapped stream gives the same writes as back to back
    do_reset();
    send_word(32'd2, 1, 0);
    send_word(32'h0000_0013, 1, 4);
    send_word(32'h0010_0093, 1, 1);
    idle(3);
    exp_q.delete();
    exp_q.push_back({12'h000, 32'h0000_0013});
    exp_q.push_back({12'h001, 32'h0010_0093});
    cmp_writes("gaps", 0);

    // Reset mid-word, then a fresh one-word load
    do_reset();
    send_word(32'd2, 0, 0);
    send_word(32'h1111_1111, 0, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    do_reset();
    send_word(32'd1, 0, 0);
    send_word(32'hAABB_CCDD, 0, 0);
    idle(3);
    exp_q.delete();
    exp_q.push_back({12'h000, 32'hAABB_CCDD});
    cmp_writes("rst_mid", 0);
    check("rst_mid.load_done", 64'(load_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
